// File: rtl/uart_rx_fifo.sv
// Purpose : receive-side FWFT buffer between rx_asm and the host; holds {error,data} words.
// Latency : a word written at edge N is presented (out_valid=1) right after edge N.
// Backpres: none toward rx_asm (words arriving while full are dropped and flagged);
//           host side is valid/ready.
//
// Ports
//   clk, rst_n             clock (rising edge) and async active-low reset
//   in_valid/in_data/in_error   single-cycle word strobe from rx_asm
//   out_valid/out_ready/out_data/out_error   first-word-fall-through host stream
//   count/full/empty       fill level (count held in its own register)
//   overflow/clr_overflow  sticky drop flag and its clear pulse
//   ovf_count              dropped-word counter
//
// Build option: define UART_RX_FIFO_OVF_CNT_EN to build an 8-bit saturating
// dropped-word counter on ovf_count. Without it, ovf_count is tied to zero.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_error,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_error,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic [7:0]            ovf_count
);

    // Storage: bit DATA_WIDTH holds the error flag, the rest holds the data.
    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_nxt;

    logic pop;
    logic wr_en;
    logic drop;

    // out_ready while empty is ignored because out_valid gates the pop.
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    // A pop in the same cycle frees the head slot, so a full FIFO still
    // accepts the incoming word without a drop.
    assign wr_en = in_valid && (!full || pop);
    assign drop  = in_valid && full && !pop;

    // Outputs read as zero while empty, even though the array is not reset.
    always_comb begin
        out_data  = '0;
        out_error = 1'b0;
        if (!empty) begin
            out_data  = mem[rd_ptr][DATA_WIDTH-1:0];
            out_error = mem[rd_ptr][DATA_WIDTH];
        end
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {in_error, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Write and pop together leave the level unchanged.
    always_comb begin
        count_nxt = count;
        if (wr_en && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !wr_en) begin
            count_nxt = count - 1'b1;
        end
    end

    // full/empty are registered from the next count, so they line up with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // A drop in the same cycle as a clear wins, so no drop goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_OVF_CNT_EN
    // Saturates at 255. Only reset clears it; clr_overflow has no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (drop && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end
`else
    assign ovf_count = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose : directed bench for uart_rx_fifo with hand-computed expectations.
// Latency : inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpres: drives out_ready explicitly per scenario.
module tb_uart_rx_fifo;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_error;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_error;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        clr_overflow;
    logic [7:0]  ovf_count;

    int n_vec;
    int n_err;

`ifdef UART_RX_FIFO_OVF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    uart_rx_fifo #(.DATA_WIDTH(16), .DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_error     (in_error),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_error    (out_error),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .ovf_count    (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic e);
        in_valid = 1'b1;
        in_data  = d;
        in_error = e;
        step();
        in_valid = 1'b0;
        in_error = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_error     = 1'b0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;

        // Reset state
        #12;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ovfcnt", ovf_count, 0);
        chk("rst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // out_ready while empty is ignored
        pop1();
        chk("empty_pop_count", count, 0);
        chk("empty_pop_empty", empty, 1);

        // 1: single word, 1-cycle latency, then pop
        push(16'hFCFC, 1'b0);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 16'hFCFC);
        chk("t1_err", out_error, 0);
        chk("t1_count", count, 1);
        pop1();
        chk("t1_empty", empty, 1);
        chk("t1_count0", count, 0);
        chk("t1_data0", out_data, 0);

        // 2: fill 1..8 (pointers start at 1, so they wrap), drain in order
        for (int i = 1; i <= 8; i++) push(16'(i), 1'b0);
        chk("t2_full", full, 1);
        chk("t2_count", count, 8);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t2_drain%0d", i), out_data, i);
            pop1();
        end
        chk("t2_empty", empty, 1);
        chk("t2_count0", count, 0);

        // 3: overflow drop
        for (int i = 0; i < 8; i++) push(16'h0010 + 16'(i), 1'b0);
        push(16'hDEAD, 1'b0);
        chk("t3_ovf", overflow, 1);
        chk("t3_count", count, 8);
        chk("t3_full", full, 1);
        chk("t3_head", out_data, 16'h0010);
        chk("t3_ovfcnt", ovf_count, CNT_EN ? 1 : 0);

        // clear without drop
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_ovfcnt", ovf_count, CNT_EN ? 1 : 0);

        // 4: full, write + pop in same cycle
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t4_count", count, 8);
        chk("t4_ovf", overflow, 0);
        chk("t4_head", out_data, 16'h0011);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("t4_drain%0d", i), out_data, 16'h0010 + i);
            pop1();
        end
        chk("t4_tail", out_data, 16'hBEEF);
        pop1();
        chk("t4_empty", empty, 1);

        // 5: error word, then clear colliding with a drop
        push(16'h1234, 1'b1);
        chk("t5_err", out_error, 1);
        chk("t5_data", out_data, 16'h1234);
        pop1();
        for (int i = 0; i < 8; i++) push(16'h0020 + 16'(i), 1'b0);
        in_valid     = 1'b1;
        in_data      = 16'hDEAD;
        clr_overflow = 1'b1;
        step();
        in_valid     = 1'b0;
        clr_overflow = 1'b0;
        chk("t5_setwins", overflow, 1);
        chk("t5_ovfcnt", ovf_count, CNT_EN ? 2 : 0);
        chk("t5_head", out_data, 16'h0020);

        // Mid-stream reset
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_count", count, 0);
        chk("mrst_empty", empty, 1);
        chk("mrst_ovf", overflow, 0);
        chk("mrst_ovfcnt", ovf_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 6: words as rx_asm would deliver them, spaced apart
        push(16'hFCFC, 1'b0);
        step();
        step();
        push(16'h00FF, 1'b0);
        chk("t6_count", count, 2);
        chk("t6_w0", out_data, 16'hFCFC);
        chk("t6_e0", out_error, 0);
        pop1();
        chk("t6_w1", out_data, 16'h00FF);
        chk("t6_e1", out_error, 0);
        pop1();
        chk("t6_empty", empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
